lms_tap_engine: RTL and testbench

- Time-multiplexed, parametrised successor of the FSE LMS coefficient updater.
- Holds NUM_TAPS complex taps and a rate-2 input shifter. One complex MAC lane serially applies a leaky LMS or sign-error LMS update, one tap per cycle.
- A valid/ready handshake accepts each baud-rate error sample. Step and leak are runtime-selectable.
- Sits between the FSE filter (consumes o_taps_*) and the slicer/error block (drives i_err_*).

---
 rtl/lms_pkg.sv | 38 +++
 rtl/lms_cmac.sv | 135 +++++++++++++
 rtl/lms_tap_engine.sv | 233 +++++++++++++++++++++++
 tb/tb_lms_tap_engine.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lms_pkg.sv
// Shared helpers, derived-width functions, FSM encoding and tap init value
// for the LMS tap engine and its complex MAC lane.
package lms_pkg;

    function automatic int max_f(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Gradient width once its binary point sits at the tap fraction position.
    function automatic int align_w_f(input int nbt_g, input int nbf_g, input int nbf_t);
        return nbt_g - nbf_g + nbf_t;
    endfunction

    function automatic int sum_w_f(input int nbt_t, input int nbf_t, input int nbt_g, input int nbf_g);
        return nbt_t + max_f((nbt_g - nbf_g) - (nbt_t - nbf_t), 0) + 2;
    endfunction

    function automatic longint init_tap_f(input int nbf_t);
        return 64'sd1 <<< nbf_t;
    endfunction

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/lms_cmac.sv
// Complex MAC lane: stage 1 forms the gradient for one tap, stage 2 aligns,
// applies step and leak, adds to the current tap and saturates.
module lms_cmac
    import lms_pkg::*;
#(
    parameter int NBT_IN     = 8,
    parameter int NBF_IN     = 7,
    parameter int NBT_ERR    = 12,
    parameter int NBF_ERR    = 9,
    parameter int NBT_TAPS   = 28,
    parameter int NBF_TAPS   = 25,
    parameter int NB_STEP_SH = 4,
    parameter int LEAK_SH    = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       srst,
    input  logic                       s1_valid,
    input  logic                       mode,
    input  logic                       leak_en,
    input  logic signed [NBT_IN-1:0]   x_i,
    input  logic signed [NBT_IN-1:0]   x_q,
    input  logic signed [NBT_ERR-1:0]  err_i,
    input  logic signed [NBT_ERR-1:0]  err_q,
    input  logic [NB_STEP_SH-1:0]      step_sh,
    input  logic signed [NBT_TAPS-1:0] tap_i,
    input  logic signed [NBT_TAPS-1:0] tap_q,
    output logic                       s2_valid,
    output logic signed [NBT_TAPS-1:0] new_i,
    output logic signed [NBT_TAPS-1:0] new_q,
    output logic                       sat_i,
    output logic                       sat_q
);

    localparam int NBT_P = NBT_ERR + NBT_IN;
    localparam int NBT_G = NBT_P + 1;
    localparam int NBF_G = NBF_ERR + NBF_IN;
    localparam int NBT_A = align_w_f(NBT_G, NBF_G, NBF_TAPS);
    localparam int NBT_S = sum_w_f(NBT_TAPS, NBF_TAPS, NBT_G, NBF_G);
    localparam int E_ONE = 1 << NBF_ERR;
    localparam logic signed [NBT_ERR-1:0] E_POS = NBT_ERR'(E_ONE);
    localparam logic signed [NBT_ERR-1:0] E_NEG = NBT_ERR'(-E_ONE);

    logic signed [NBT_ERR-1:0] e_i_s, e_q_s;
    logic signed [NBT_P-1:0]   p_ii_s, p_qq_s, p_iq_s, p_qi_s;
    logic signed [NBT_G-1:0]   g_i_s, g_q_s, g_i_r, g_q_r;
    logic                      valid_r;
    logic signed [NBT_A-1:0]   a_i_s, a_q_s;
    logic signed [NBT_S-1:0]   tap_ext_i_s, tap_ext_q_s, grad_i_s, grad_q_s;
    logic signed [NBT_S-1:0]   leak_i_s, leak_q_s, sum_i_s, sum_q_s;

    // Clamp to S(NBT_TAPS,NBF_TAPS); MSB of the result flags saturation.
    function automatic logic [NBT_TAPS:0] sat_f(input logic signed [NBT_S-1:0] v);
        logic [NBT_S-NBT_TAPS:0] hi;
        hi = v[NBT_S-1:NBT_TAPS-1];
        if ((hi == {(NBT_S-NBT_TAPS+1){1'b0}}) || (hi == {(NBT_S-NBT_TAPS+1){1'b1}})) begin
            return {1'b0, v[NBT_TAPS-1:0]};
        end else if (v[NBT_S-1]) begin
            return {1'b1, 1'b1, {(NBT_TAPS-1){1'b0}}};
        end else begin
            return {1'b1, 1'b0, {(NBT_TAPS-1){1'b1}}};
        end
    endfunction

    // Stage 1: error select (sign-error maps 0 to +1) and complex gradient.
    always_comb begin
        e_i_s = err_i;
        e_q_s = err_q;
        if (mode) begin
            e_i_s = err_i[NBT_ERR-1] ? E_NEG : E_POS;
            e_q_s = err_q[NBT_ERR-1] ? E_NEG : E_POS;
        end else begin
            e_i_s = err_i;
            e_q_s = err_q;
        end
        p_ii_s = NBT_P'(e_i_s) * NBT_P'(x_i);
        p_qq_s = NBT_P'(e_q_s) * NBT_P'(x_q);
        p_iq_s = NBT_P'(e_i_s) * NBT_P'(x_q);
        p_qi_s = NBT_P'(e_q_s) * NBT_P'(x_i);
        g_i_s  = NBT_G'(p_ii_s) + NBT_G'(p_qq_s);
        g_q_s  = NBT_G'(p_iq_s) - NBT_G'(p_qi_s);
    end

    // Pipeline register between gradient and tap update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            g_i_r   <= {NBT_G{1'b0}};
            g_q_r   <= {NBT_G{1'b0}};
        end else if (srst) begin
            valid_r <= 1'b0;
            g_i_r   <= {NBT_G{1'b0}};
            g_q_r   <= {NBT_G{1'b0}};
        end else begin
            valid_r <= s1_valid;
            g_i_r   <= g_i_s;
            g_q_r   <= g_q_s;
        end
    end

    generate
        if (NBF_G < NBF_TAPS) begin : g_align_up
            assign a_i_s = {g_i_r, {(NBF_TAPS-NBF_G){1'b0}}};
            assign a_q_s = {g_q_r, {(NBF_TAPS-NBF_G){1'b0}}};
        end else if (NBF_G == NBF_TAPS) begin : g_align_eq
            assign a_i_s = g_i_r;
            assign a_q_s = g_q_r;
        end else begin : g_align_dn
            assign a_i_s = g_i_r[NBT_G-1 -: NBT_A];
            assign a_q_s = g_q_r[NBT_G-1 -: NBT_A];
        end
    endgenerate

    // Stage 2: step, leak, accumulate and saturate.
    always_comb begin
        tap_ext_i_s = NBT_S'(tap_i);
        tap_ext_q_s = NBT_S'(tap_q);
        grad_i_s    = NBT_S'(a_i_s) >>> step_sh;
        grad_q_s    = NBT_S'(a_q_s) >>> step_sh;
        if (leak_en) begin
            leak_i_s = tap_ext_i_s >>> LEAK_SH;
            leak_q_s = tap_ext_q_s >>> LEAK_SH;
        end else begin
            leak_i_s = {NBT_S{1'b0}};
            leak_q_s = {NBT_S{1'b0}};
        end
        sum_i_s = tap_ext_i_s - leak_i_s - grad_i_s;
        sum_q_s = tap_ext_q_s - leak_q_s + grad_q_s;
        {sat_i, new_i} = sat_f(sum_i_s);
        {sat_q, new_q} = sat_f(sum_q_s);
    end

    assign s2_valid = valid_r;

endmodule

// File: rtl/lms_tap_engine.sv
// Serial leaky / sign-error LMS tap engine: rate-2 input shifter, tap store
// and update sequencer feeding one complex MAC lane.
module lms_tap_engine
    import lms_pkg::*;
#(
    parameter int NUM_TAPS   = 11,
    parameter int NBT_IN     = 8,
    parameter int NBF_IN     = 7,
    parameter int NBT_ERR    = 12,
    parameter int NBF_ERR    = 9,
    parameter int NBT_TAPS   = 28,
    parameter int NBF_TAPS   = 25,
    parameter int NB_STEP_SH = 4,
    parameter int LEAK_SH    = 10,
    parameter int NB_SATCNT  = 16
) (
    input  logic                           clk,
    input  logic                           i_reset_n,
    input  logic [NBT_IN-1:0]              i_is_data_I,
    input  logic [NBT_IN-1:0]              i_is_data_Q,
    input  logic                           i_en_shtr,
    input  logic                           i_upd_valid,
    output logic                           o_upd_ready,
    input  logic [NBT_ERR-1:0]             i_err_I,
    input  logic [NBT_ERR-1:0]             i_err_Q,
    input  logic [NB_STEP_SH-1:0]          i_step_sh,
    input  logic                           i_leak_en,
    input  logic                           i_mode,
    input  logic                           i_freeze,
    input  logic                           i_clear,
    output logic                           o_upd_done,
    output logic                           o_upd_drop,
    output logic                           o_taps_valid,
    output logic [NUM_TAPS*NBT_TAPS-1:0]   o_taps_I,
    output logic [NUM_TAPS*NBT_TAPS-1:0]   o_taps_Q,
    output logic [NB_SATCNT-1:0]           o_sat_cnt
);

    localparam int IDX_W = clog2_f(NUM_TAPS);
    localparam int CTR   = NUM_TAPS / 2;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_TAPS - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic signed [NBT_TAPS-1:0] TAP_ONE  = NBT_TAPS'(init_tap_f(NBF_TAPS));
    localparam logic signed [NBT_TAPS-1:0] TAP_ZERO = {NBT_TAPS{1'b0}};

    logic signed [NBT_IN-1:0]   x_i_r [NUM_TAPS];
    logic signed [NBT_IN-1:0]   x_q_r [NUM_TAPS];
    logic signed [NBT_IN-1:0]   snap_i_r [NUM_TAPS];
    logic signed [NBT_IN-1:0]   snap_q_r [NUM_TAPS];
    logic signed [NBT_TAPS-1:0] tap_i_r [NUM_TAPS];
    logic signed [NBT_TAPS-1:0] tap_q_r [NUM_TAPS];
    logic signed [NBT_ERR-1:0]  err_i_r, err_q_r;
    logic [NB_STEP_SH-1:0]      step_r;
    logic                       leak_r, mode_r;
    logic [1:0]                 state_r, state_nxt_s;
    logic [IDX_W-1:0]           idx_r, idx_nxt_s, wr_idx_r;
    logic                       upd_ready_r, taps_valid_r, upd_done_r, upd_drop_r;
    logic [NB_SATCNT-1:0]       sat_cnt_r;
    logic                       accept_s, s2_valid_s, sat_i_s, sat_q_s;
    logic signed [NBT_TAPS-1:0] new_i_s, new_q_s;

    function automatic logic [NB_SATCNT-1:0] cnt_add_f(input logic [NB_SATCNT-1:0] cnt,
                                                       input logic a, input logic b);
        logic [NB_SATCNT:0] s;
        s = {1'b0, cnt} + {{NB_SATCNT{1'b0}}, a} + {{NB_SATCNT{1'b0}}, b};
        if (s[NB_SATCNT]) begin
            return {NB_SATCNT{1'b1}};
        end else begin
            return s[NB_SATCNT-1:0];
        end
    endfunction

    assign accept_s = i_upd_valid & upd_ready_r & ~i_freeze & ~i_clear;

    // Input delay line; keeps running while an update is in flight.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                x_i_r[k] <= {NBT_IN{1'b0}};
                x_q_r[k] <= {NBT_IN{1'b0}};
            end
        end else if (i_en_shtr) begin
            x_i_r[0] <= i_is_data_I;
            x_q_r[0] <= i_is_data_Q;
            for (int k = 1; k < NUM_TAPS; k++) begin
                x_i_r[k] <= x_i_r[k-1];
                x_q_r[k] <= x_q_r[k-1];
            end
        end
    end

    // Per-update context captured on accept.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                snap_i_r[k] <= {NBT_IN{1'b0}};
                snap_q_r[k] <= {NBT_IN{1'b0}};
            end
            err_i_r <= {NBT_ERR{1'b0}};
            err_q_r <= {NBT_ERR{1'b0}};
            step_r  <= {NB_STEP_SH{1'b0}};
            leak_r  <= 1'b0;
            mode_r  <= 1'b0;
        end else if (accept_s) begin
            snap_i_r <= x_i_r;
            snap_q_r <= x_q_r;
            err_i_r  <= i_err_I;
            err_q_r  <= i_err_Q;
            step_r   <= i_step_sh;
            leak_r   <= i_leak_en;
            mode_r   <= i_mode;
        end
    end

    // Sequencer next state; clear wins over everything.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        if (i_clear) begin
            state_nxt_s = ST_IDLE;
            idx_nxt_s   = IDX_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = accept_s ? ST_RUN : ST_IDLE;
                    idx_nxt_s   = IDX_ZERO;
                end
                ST_RUN: begin
                    if (idx_r == IDX_LAST) begin
                        state_nxt_s = ST_FLUSH;
                        idx_nxt_s   = IDX_ZERO;
                    end else begin
                        state_nxt_s = ST_RUN;
                        idx_nxt_s   = idx_r + IDX_ONE;
                    end
                end
                ST_FLUSH: state_nxt_s = ST_DONE;
                ST_DONE:  state_nxt_s = ST_IDLE;
                default: begin
                    state_nxt_s = ST_IDLE;
                    idx_nxt_s   = IDX_ZERO;
                end
            endcase
        end
    end

    // Sequencer state and registered status outputs.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r      <= ST_IDLE;
            idx_r        <= IDX_ZERO;
            wr_idx_r     <= IDX_ZERO;
            upd_ready_r  <= 1'b1;
            taps_valid_r <= 1'b1;
            upd_done_r   <= 1'b0;
            upd_drop_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            idx_r        <= idx_nxt_s;
            wr_idx_r     <= idx_r;
            upd_ready_r  <= (state_nxt_s == ST_IDLE);
            taps_valid_r <= (state_nxt_s == ST_IDLE);
            upd_done_r   <= (state_nxt_s == ST_DONE);
            upd_drop_r   <= i_upd_valid & ~i_freeze & ~upd_ready_r & ~i_clear;
        end
    end

    lms_cmac #(
        .NBT_IN     (NBT_IN),
        .NBF_IN     (NBF_IN),
        .NBT_ERR    (NBT_ERR),
        .NBF_ERR    (NBF_ERR),
        .NBT_TAPS   (NBT_TAPS),
        .NBF_TAPS   (NBF_TAPS),
        .NB_STEP_SH (NB_STEP_SH),
        .LEAK_SH    (LEAK_SH)
    ) u_cmac (
        .clk      (clk),
        .rst_n    (i_reset_n),
        .srst     (i_clear),
        .s1_valid (state_r == ST_RUN),
        .mode     (mode_r),
        .leak_en  (leak_r),
        .x_i      (snap_i_r[idx_r]),
        .x_q      (snap_q_r[idx_r]),
        .err_i    (err_i_r),
        .err_q    (err_q_r),
        .step_sh  (step_r),
        .tap_i    (tap_i_r[wr_idx_r]),
        .tap_q    (tap_q_r[wr_idx_r]),
        .s2_valid (s2_valid_s),
        .new_i    (new_i_s),
        .new_q    (new_q_s),
        .sat_i    (sat_i_s),
        .sat_q    (sat_q_s)
    );

    // Tap store with stage-2 writeback and saturation event counter.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int m = 0; m < NUM_TAPS; m++) begin
                tap_i_r[m] <= (m == CTR) ? TAP_ONE : TAP_ZERO;
                tap_q_r[m] <= TAP_ZERO;
            end
            sat_cnt_r <= {NB_SATCNT{1'b0}};
        end else if (i_clear) begin
            for (int m = 0; m < NUM_TAPS; m++) begin
                tap_i_r[m] <= (m == CTR) ? TAP_ONE : TAP_ZERO;
                tap_q_r[m] <= TAP_ZERO;
            end
            sat_cnt_r <= {NB_SATCNT{1'b0}};
        end else if (s2_valid_s) begin
            tap_i_r[wr_idx_r] <= new_i_s;
            tap_q_r[wr_idx_r] <= new_q_s;
            sat_cnt_r         <= cnt_add_f(sat_cnt_r, sat_i_s, sat_q_s);
        end
    end

    generate
        for (genvar m = 0; m < NUM_TAPS; m++) begin : g_taps
            assign o_taps_I[(m+1)*NBT_TAPS-1 -: NBT_TAPS] = tap_i_r[m];
            assign o_taps_Q[(m+1)*NBT_TAPS-1 -: NBT_TAPS] = tap_q_r[m];
        end
    endgenerate

    assign o_upd_ready  = upd_ready_r;
    assign o_taps_valid = taps_valid_r;
    assign o_upd_done   = upd_done_r;
    assign o_upd_drop   = upd_drop_r;
    assign o_sat_cnt    = sat_cnt_r;

endmodule

// File: tb/tb_lms_tap_engine.sv
// Directed bench for lms_tap_engine: vector table of single updates plus
// hand-written sequences for saturation repeat, clear, drop and reset.
module tb_lms_tap_engine;

    localparam int NT = 11;
    localparam int TW = 28;
    localparam int CT = 5;

    logic            clk;
    logic            i_reset_n;
    logic [7:0]      i_is_data_I, i_is_data_Q;
    logic            i_en_shtr, i_upd_valid, i_leak_en, i_mode, i_freeze, i_clear;
    logic [11:0]     i_err_I, i_err_Q;
    logic [3:0]      i_step_sh;
    logic            o_upd_ready, o_upd_done, o_upd_drop, o_taps_valid;
    logic [NT*TW-1:0] o_taps_I, o_taps_Q;
    logic [15:0]     o_sat_cnt;

    int n_checks;
    int n_errors;

    lms_tap_engine dut (
        .clk          (clk),
        .i_reset_n    (i_reset_n),
        .i_is_data_I  (i_is_data_I),
        .i_is_data_Q  (i_is_data_Q),
        .i_en_shtr    (i_en_shtr),
        .i_upd_valid  (i_upd_valid),
        .o_upd_ready  (o_upd_ready),
        .i_err_I      (i_err_I),
        .i_err_Q      (i_err_Q),
        .i_step_sh    (i_step_sh),
        .i_leak_en    (i_leak_en),
        .i_mode       (i_mode),
        .i_freeze     (i_freeze),
        .i_clear      (i_clear),
        .o_upd_done   (o_upd_done),
        .o_upd_drop   (o_upd_drop),
        .o_taps_valid (o_taps_valid),
        .o_taps_I     (o_taps_I),
        .o_taps_Q     (o_taps_Q),
        .o_sat_cnt    (o_sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]    xi;
        logic [7:0]    xq;
        logic [11:0]   ei;
        logic [11:0]   eq;
        logic [3:0]    step;
        logic          leak;
        logic          mode;
        logic [TW-1:0] exp_i;
        logic [TW-1:0] exp_q;
        logic [15:0]   exp_sat;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [TW-1:0] tap_of(input logic [NT*TW-1:0] bus, input int m);
        return bus[m*TW +: TW];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // OR of every tap except the centre I tap and centre Q tap.
    function automatic logic [TW-1:0] others_or();
        logic [TW-1:0] acc;
        acc = '0;
        for (int m = 0; m < NT; m++) begin
            if (m != CT) begin
                acc = acc | tap_of(o_taps_I, m) | tap_of(o_taps_Q, m);
            end
        end
        return acc;
    endfunction

    task automatic do_clear();
        i_clear = 1'b1;
        @(negedge clk);
        i_clear = 1'b0;
    endtask

    // Eleven shifts leave (xi,xq) at x[5] and zeros everywhere else.
    task automatic load_x(input logic [7:0] xi, input logic [7:0] xq);
        for (int j = 0; j < NT; j++) begin
            i_en_shtr   = 1'b1;
            i_is_data_I = (j == CT) ? xi : 8'h00;
            i_is_data_Q = (j == CT) ? xq : 8'h00;
            @(negedge clk);
        end
        i_en_shtr   = 1'b0;
        i_is_data_I = 8'h00;
        i_is_data_Q = 8'h00;
    endtask

    task automatic start_update(input logic [11:0] ei, input logic [11:0] eq, input logic [3:0] step,
                                input logic leak, input logic mode);
        i_err_I     = ei;
        i_err_Q     = eq;
        i_step_sh   = step;
        i_leak_en   = leak;
        i_mode      = mode;
        i_upd_valid = 1'b1;
    endtask

    // Returns the number of cycles from the accept cycle to the done pulse, -1 on timeout.
    task automatic run_update(input logic [11:0] ei, input logic [11:0] eq, input logic [3:0] step,
                              input logic leak, input logic mode, output int lat);
        start_update(ei, eq, step, leak, mode);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            i_upd_valid = 1'b0;
            if (o_upd_done) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int n_done;
        int n_drop;

        n_checks = 0;
        n_errors = 0;
        vecs[0] = '{8'h40, 8'h00, 12'h200, 12'h000, 4'd4,  1'b0, 1'b0, 28'h1F00000, 28'h0000000, 16'd0};
        vecs[1] = '{8'h80, 8'h00, 12'h7FF, 12'h000, 4'd0,  1'b0, 1'b0, 28'h7FFFFFF, 28'h0000000, 16'd1};
        vecs[2] = '{8'h40, 8'h00, 12'h001, 12'hFFF, 4'd4,  1'b0, 1'b1, 28'h1F00000, 28'h0100000, 16'd0};
        vecs[3] = '{8'h00, 8'h00, 12'h000, 12'h000, 4'd4,  1'b1, 1'b0, 28'h1FF8000, 28'h0000000, 16'd0};
        vecs[4] = '{8'h00, 8'h40, 12'h200, 12'h000, 4'd4,  1'b0, 1'b0, 28'h2000000, 28'h0100000, 16'd0};
        vecs[5] = '{8'h7F, 8'h7F, 12'h7FF, 12'h7FF, 4'd0,  1'b0, 1'b0, 28'h8000000, 28'h0000000, 16'd1};
        vecs[6] = '{8'h40, 8'h00, 12'h200, 12'h000, 4'd15, 1'b0, 1'b0, 28'h1FFFE00, 28'h0000000, 16'd0};
        vecs[7] = '{8'h40, 8'h00, 12'hFFF, 12'h001, 4'd4,  1'b0, 1'b1, 28'h2100000, 28'hFF00000, 16'd0};
        vecs[8] = '{8'h40, 8'h00, 12'h000, 12'h000, 4'd4,  1'b0, 1'b1, 28'h1F00000, 28'hFF00000, 16'd0};
        vecs[9] = '{8'h40, 8'h00, 12'h200, 12'h000, 4'd4,  1'b1, 1'b0, 28'h1EF8000, 28'h0000000, 16'd0};

        i_reset_n = 1'b0;
        i_is_data_I = 8'h00; i_is_data_Q = 8'h00;
        i_en_shtr = 1'b0; i_upd_valid = 1'b0; i_leak_en = 1'b0; i_mode = 1'b0;
        i_freeze = 1'b0; i_clear = 1'b0; i_err_I = 12'h000; i_err_Q = 12'h000; i_step_sh = 4'd0;
        repeat (3) @(negedge clk);
        i_reset_n = 1'b1;
        @(negedge clk);
        chk("reset_tapI5", tap_of(o_taps_I, CT), 28'h2000000);
        chk("reset_tapQ5", tap_of(o_taps_Q, CT), 28'h0);
        chk("reset_others", others_or(), 28'h0);
        chk("reset_ready", o_upd_ready, 1'b1);
        chk("reset_taps_valid", o_taps_valid, 1'b1);
        chk("reset_sat_cnt", o_sat_cnt, 16'd0);
        chk("reset_done", o_upd_done, 1'b0);

        for (int v = 0; v < 10; v++) begin
            do_clear();
            load_x(vecs[v].xi, vecs[v].xq);
            run_update(vecs[v].ei, vecs[v].eq, vecs[v].step, vecs[v].leak, vecs[v].mode, lat);
            chk($sformatf("v%0d_latency", v), lat, 13);
            chk($sformatf("v%0d_tapI5", v), tap_of(o_taps_I, CT), vecs[v].exp_i);
            chk($sformatf("v%0d_tapQ5", v), tap_of(o_taps_Q, CT), vecs[v].exp_q);
            chk($sformatf("v%0d_others", v), others_or(), 28'h0);
            chk($sformatf("v%0d_sat_cnt", v), o_sat_cnt, vecs[v].exp_sat);
            @(negedge clk);
            chk($sformatf("v%0d_taps_valid", v), o_taps_valid, 1'b1);
        end

        // Repeated saturating update keeps the clamp and counts again.
        do_clear();
        load_x(8'h80, 8'h00);
        run_update(12'h7FF, 12'h000, 4'd0, 1'b0, 1'b0, lat);
        chk("sat1_tapI5", tap_of(o_taps_I, CT), 28'h7FFFFFF);
        chk("sat1_cnt", o_sat_cnt, 16'd1);
        @(negedge clk);
        run_update(12'h7FF, 12'h000, 4'd0, 1'b0, 1'b0, lat);
        chk("sat2_latency", lat, 13);
        chk("sat2_tapI5", tap_of(o_taps_I, CT), 28'h7FFFFFF);
        chk("sat2_cnt", o_sat_cnt, 16'd2);
        @(negedge clk);

        // Clear in RUN after tap 5 has been written with leak applied.
        start_update(12'h000, 12'h000, 4'd0, 1'b1, 1'b0);
        n_done = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            i_upd_valid = 1'b0;
            if (o_upd_done) n_done++;
            if (i == 8) begin
                chk("clr_pre_tapI5", tap_of(o_taps_I, CT), 28'h7FE0000);
                chk("clr_pre_cnt", o_sat_cnt, 16'd2);
                i_clear = 1'b1;
            end else begin
                i_clear = 1'b0;
            end
            if (i == 9) begin
                chk("clr_tapI5", tap_of(o_taps_I, CT), 28'h2000000);
                chk("clr_others", others_or(), 28'h0);
                chk("clr_cnt", o_sat_cnt, 16'd0);
                chk("clr_ready", o_upd_ready, 1'b1);
            end
        end
        chk("clr_no_done", n_done, 0);

        // Valid three cycles after accept is dropped without touching taps.
        do_clear();
        start_update(12'h000, 12'h000, 4'd0, 1'b1, 1'b0);
        n_done = 0;
        n_drop = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (o_upd_done) n_done++;
            if (o_upd_drop) n_drop++;
            if (i == 3) begin
                chk("busy_ready", o_upd_ready, 1'b0);
                chk("busy_taps_valid", o_taps_valid, 1'b0);
                i_upd_valid = 1'b1;
            end else begin
                i_upd_valid = 1'b0;
            end
            if (i == 4) chk("drop_pulse", o_upd_drop, 1'b1);
        end
        chk("drop_done_count", n_done, 1);
        chk("drop_count", n_drop, 1);
        chk("drop_tapI5", tap_of(o_taps_I, CT), 28'h1FF8000);

        // Async reset in the middle of an update.
        do_clear();
        start_update(12'h000, 12'h000, 4'd0, 1'b1, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            i_upd_valid = 1'b0;
        end
        chk("rst_pre_tapI5", tap_of(o_taps_I, CT), 28'h1FF8000);
        chk("rst_pre_taps_valid", o_taps_valid, 1'b0);
        i_reset_n = 1'b0;
        #1;
        chk("rst_tapI5", tap_of(o_taps_I, CT), 28'h2000000);
        chk("rst_others", others_or(), 28'h0);
        chk("rst_ready", o_upd_ready, 1'b1);
        chk("rst_taps_valid", o_taps_valid, 1'b1);
        @(negedge clk);
        i_reset_n = 1'b1;
        n_done = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (o_upd_done) n_done++;
        end
        chk("rst_no_done", n_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
